// File: rtl/half_adder_pkg.sv
// Shared types and defaults for the registered bit-parallel half adder.
package half_adder_pkg;

    localparam int HA_DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_lane_t;

    function automatic ha_lane_t ha_eval(input logic a, input logic b);
        ha_lane_t lane;
        lane.sum   = a ^ b;
        lane.carry = a & b;
        return lane;
    endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Combinational 1-bit half-adder cell.
module half_adder_bit
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    ha_lane_t lane;

    always_comb begin
        lane  = ha_eval(a, b);
        sum   = lane.sum;
        carry = lane.carry;
    end

endmodule

// File: rtl/half_adder.sv
// Registered bit-parallel half adder: per-lane sum/carry, no inter-lane carry.
// Optional carry_any/sum_zero flag outputs are enabled by HALF_ADDER_FLAGS_EN.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid
`ifdef HALF_ADDER_FLAGS_EN
    ,
    output logic             carry_any,
    output logic             sum_zero
`endif
);

    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] carry_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_bit u_bit (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum_next[i]),
            .carry (carry_next[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry     <= '0;
            out_valid <= 1'b0;
        end else begin
            sum       <= sum_next;
            carry     <= carry_next;
            out_valid <= 1'b1;
        end
    end

`ifdef HALF_ADDER_FLAGS_EN
    // Flags are derived from the next values so they line up with sum/carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_any <= 1'b0;
            sum_zero  <= 1'b1;
        end else begin
            carry_any <= |carry_next;
            sum_zero  <= ~(|sum_next);
        end
    end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: directed cases plus a full 4-bit operand sweep.
// Flag outputs are also checked when HALF_ADDER_FLAGS_EN is defined.
module tb_half_adder;
    import half_adder_pkg::*;

    localparam int W = HA_DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic [W-1:0] carry;
    logic         out_valid;
`ifdef HALF_ADDER_FLAGS_EN
    logic         carry_any;
    logic         sum_zero;
`endif

    always #5 clk = ~clk;

    half_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .carry     (carry),
        .out_valid (out_valid)
`ifdef HALF_ADDER_FLAGS_EN
        ,
        .carry_any (carry_any),
        .sum_zero  (sum_zero)
`endif
    );

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive one operand pair, queue its expected result, compare after the edge.
    task automatic drive(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ri,
                         input logic [W-1:0] es, input logic [W-1:0] ec, input logic ev,
                         input string tag);
        exp_t e;
        a   = ai;
        b   = bi;
        rst = ri;
        sb.push_back('{es, ec, ev});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val({tag, ".sum"}, 64'(sum), 64'(e.s));
        check_val({tag, ".carry"}, 64'(carry), 64'(e.c));
        check_val({tag, ".valid"}, 64'(out_valid), 64'(e.v));
`ifdef HALF_ADDER_FLAGS_EN
        check_val({tag, ".carry_any"}, 64'(carry_any), 64'(|e.c));
        check_val({tag, ".sum_zero"}, 64'(sum_zero), 64'(e.s == '0));
`endif
    endtask

    initial begin
        rst = 1'b1;
        a   = 4'b1111;
        b   = 4'b1111;

        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "reset0");
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, "reset1");

        drive(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, "tt00");
        drive(4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, "tt01");
        drive(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, "tt10");
        drive(4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b1, "tt11");

        drive(4'b1111, 4'b0101, 1'b0, 4'b1010, 4'b0101, 1'b1, "indep0");
        drive(4'b1010, 4'b0101, 1'b0, 4'b1111, 4'b0000, 1'b1, "indep1");

        // Operands changing between edges must not reach the outputs.
        a = 4'b1111;
        b = 4'b1111;
        #3;
        check_val("hold.sum", 64'(sum), 64'(4'b1111));
        check_val("hold.carry", 64'(carry), 64'(4'b0000));
        @(negedge clk);

        drive(4'b0011, 4'b0110, 1'b0, 4'b0101, 4'b0010, 1'b1, "mid0");
        drive(4'b0011, 4'b0110, 1'b1, 4'b0000, 4'b0000, 1'b0, "midrst");
        drive(4'b0011, 4'b0110, 1'b0, 4'b0101, 4'b0010, 1'b1, "mid1");

        drive(4'b0101, 4'b0101, 1'b0, 4'b0000, 4'b0101, 1'b1, "flag0");
        drive(4'b0110, 4'b0000, 1'b0, 4'b0110, 4'b0000, 1'b1, "flag1");

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                logic [W-1:0] va;
                logic [W-1:0] vb;
                va = W'(ia);
                vb = W'(ib);
                drive(va, vb, 1'b0, va ^ vb, va & vb, 1'b1,
                      $sformatf("sweep_%0h_%0h", va, vb));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
